apm_mac_seq: RTL
================

APM_MAC_SEQ -- requirements
Module: apm_mac_seq

Interface
REQ-001 SHALL have parameter MAX_LEN, default 9: maximum dot-product length in terms.
REQ-002 SHALL have parameter APM_LAT, default 2: APM input-to-P latency in cycles (M reg + P reg).
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin a dot product; sampled only in IDLE.
REQ-006 SHALL have port len, input, $clog2(MAX_LEN+1) bits: term count, latched with start.
REQ-007 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 SHALL have ports op_valid (input, 1) and op_ready (output, 1): operand handshake.
REQ-009 SHALL have ports op_x_low, op_y_low, op_x_high and op_y_high, each input, 9 bits: signed operand lanes.
REQ-010 SHALL have ports apm_low_x, apm_low_y, apm_high_x and apm_high_y, each output, 9 bits: drive to the APM.
REQ-011 SHALL have ports apm_low_z and apm_high_z, each output, 24 bits: addend drive to the APM.
REQ-012 SHALL have port apm_data_valid, output, 1 bit: issue strobe to the APM.
REQ-013 SHALL have ports apm_low_p and apm_high_p, each input, 24 bits: returned APM results.
REQ-014 SHALL have ports res_valid (output, 1) and res_ready (input, 1): result handshake.
REQ-015 SHALL have ports res_low and res_high, each output, 24 bits: final signed sums.

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
REQ-017 In IDLE with start=1: len=0 SHALL go to DONE with zero results; otherwise SHALL latch len, clear the term counter, clear both accumulators and go to ISSUE.
REQ-018 op_ready SHALL be 1 only in ISSUE; a term issues on op_valid&op_ready, else the FSM stalls in ISSUE.
REQ-019 On issue, apm_*_x/y SHALL carry the op lanes, apm_*_z SHALL carry the accumulators (0 for the first term), apm_data_valid=1, and the FSM SHALL enter WAIT; outside issue, apm_data_valid=0 and x/y/z=0.
REQ-020 A term issued in cycle t SHALL have apm_*_p loaded into the accumulators at the end of cycle t+APM_LAT; WAIT SHALL last APM_LAT cycles, giving one term per APM_LAT+1 cycles.
REQ-021 After the load, the FSM SHALL go to DONE if the count equals len, else to ISSUE.
REQ-022 With start in cycle s, op_valid held high and res_ready held high, res_valid SHALL first rise in cycle s+(APM_LAT+1)*len+1.
REQ-023 DONE SHALL hold res_valid=1 and res_* stable until res_ready=1, then return to IDLE.
REQ-024 The low and high lanes SHALL be independent; 24-bit arithmetic SHALL wrap two's-complement unless REQ-028 applies.
REQ-025 start SHALL be ignored while busy; len>MAX_LEN SHALL be clamped to MAX_LEN.

Reset
REQ-026 rstn=0 at a clock edge, including mid-operation, SHALL force IDLE and zero the accumulators and counter. Outputs SHALL reset to op_ready=0, apm_data_valid=0, all apm_* buses=0, res_valid=0, res_*=0 and busy=0. Late APM results SHALL be ignored.

Configuration
REQ-027 Macro APM_MAC_SAT_EN SHALL select result saturation.
REQ-028 With APM_MAC_SAT_EN defined, res_* SHALL saturate to the signed 16-bit range [-32768, 32767], sign-extended to 24 bits; without it, res_* SHALL be the raw accumulators.

Structure
REQ-029 Package conv_pkg SHALL hold the APM_LAT default, the 9/24-bit lane widths and the FSM state enum.
REQ-030 Saturation SHALL live in sub-module apm_sat24 (24 to 16 bits, sign-extended); the APM instance SHALL sit in the parent, not inside this block.

Verification
REQ-031 len=3, lows (1,2), (3,4) and (-5,6), highs (7,7) each term -> res_low=-16, res_high=147, res_valid in cycle s+10.
REQ-032 len=0 start -> DONE with res_low=res_high=0 and no apm_data_valid pulse.
REQ-033 op_valid low for 5 cycles mid-sequence -> FSM stalls in ISSUE, sum unchanged, one apm_data_valid per term.
REQ-034 res_ready held low 4 cycles in DONE -> res_* stable, a new start is ignored, then IDLE the cycle after res_ready=1.
REQ-035 rstn pulsed low during WAIT -> next cycle IDLE, all outputs 0, and the late apm_*_p is not captured.
REQ-036 APM_MAC_SAT_EN defined, len=3, each term -128*-128 -> res_low=32767; without the macro -> 49152.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared lane widths, APM latency default and FSM states for apm_mac_seq
package conv_pkg;
  localparam int APM_LAT_DEF = 2;
  localparam int OP_W = 9;
  localparam int ACC_W = 24;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/apm_sat24.sv
// apm_sat24: clamp a signed 24-bit sum to the signed 16-bit range
module apm_sat24
  import conv_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  output logic [15:0]      q
);
  logic pos_ovf, neg_ovf;
  assign pos_ovf = !a[ACC_W-1] && (|a[ACC_W-2:15]);
  assign neg_ovf = a[ACC_W-1] && !(&a[ACC_W-2:15]);
  assign q = pos_ovf ? 16'h7fff : neg_ovf ? 16'h8000 : a[15:0];
endmodule

// File: rtl/apm_mac_seq.sv
// apm_mac_seq: dual-lane dot-product sequencer around an external APM (P = X*Y + Z).
// Define APM_MAC_SAT_EN to saturate results to signed 16 bits.
module apm_mac_seq
  import conv_pkg::*;
#(
  parameter int MAX_LEN = 9,
  parameter int APM_LAT = APM_LAT_DEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start,
  input  logic [$clog2(MAX_LEN+1)-1:0] len,
  output logic                         busy,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [OP_W-1:0]              op_x_low,
  input  logic [OP_W-1:0]              op_y_low,
  input  logic [OP_W-1:0]              op_x_high,
  input  logic [OP_W-1:0]              op_y_high,
  output logic [OP_W-1:0]              apm_low_x,
  output logic [OP_W-1:0]              apm_low_y,
  output logic [OP_W-1:0]              apm_high_x,
  output logic [OP_W-1:0]              apm_high_y,
  output logic [ACC_W-1:0]             apm_low_z,
  output logic [ACC_W-1:0]             apm_high_z,
  output logic                         apm_data_valid,
  input  logic [ACC_W-1:0]             apm_low_p,
  input  logic [ACC_W-1:0]             apm_high_p,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ACC_W-1:0]             res_low,
  output logic [ACC_W-1:0]             res_high
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int WW = $clog2(APM_LAT + 1);
  state_t state, state_nx;
  logic [LW-1:0] cnt, len_q, len_c;
  logic [WW-1:0] wcnt;
  logic [ACC_W-1:0] acc_low, acc_high;
  logic issue, load;
  assign len_c = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
  assign issue = (state == ISSUE) && op_valid;
  // P for the term in flight is valid on the last WAIT cycle
  assign load = (state == WAIT) && (wcnt == WW'(APM_LAT - 1));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = !start ? IDLE : (len == '0) ? DONE : ISSUE;
      ISSUE:   state_nx = op_valid ? WAIT : ISSUE;
      WAIT:    state_nx = !load ? WAIT : (cnt == len_q) ? DONE : ISSUE;
      default: state_nx = res_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      len_q    <= '0;
      wcnt     <= '0;
      acc_low  <= '0;
      acc_high <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        len_q    <= len_c;
        cnt      <= '0;
        acc_low  <= '0;
        acc_high <= '0;
      end
      if (issue) begin
        cnt  <= cnt + LW'(1);
        wcnt <= '0;
      end else if (state == WAIT) begin
        wcnt <= wcnt + WW'(1);
      end
      if (load) begin
        acc_low  <= apm_low_p;
        acc_high <= apm_high_p;
      end
    end
  end
  assign busy           = state != IDLE;
  assign op_ready       = state == ISSUE;
  assign apm_data_valid = issue;
  assign apm_low_x      = issue ? op_x_low : '0;
  assign apm_low_y      = issue ? op_y_low : '0;
  assign apm_high_x     = issue ? op_x_high : '0;
  assign apm_high_y     = issue ? op_y_high : '0;
  assign apm_low_z      = issue ? acc_low : '0;
  assign apm_high_z     = issue ? acc_high : '0;
  assign res_valid      = state == DONE;
`ifdef APM_MAC_SAT_EN
  logic [15:0] sat_low, sat_high;
  apm_sat24 u_sat_low  (.a(acc_low),  .q(sat_low));
  apm_sat24 u_sat_high (.a(acc_high), .q(sat_high));
  assign res_low  = {{(ACC_W-16){sat_low[15]}}, sat_low};
  assign res_high = {{(ACC_W-16){sat_high[15]}}, sat_high};
`else
  assign res_low  = acc_low;
  assign res_high = acc_high;
`endif
endmodule
